fifo_lector: RTL
================

Name: fifo_lector

Overview:
Read-side controller for the team's `fifo`. It pops words from the FIFO by watching empty/almost_empty and driving read_enable, then presents them downstream on a valid/ready handshake. It absorbs the FIFO's one-cycle read latency with a 2-entry output buffer, so no word is lost or duplicated under downstream back-pressure. It also counts delivered words and flags protocol errors.

Parameters:
tamano_datos, 10, width of FIFO data words
tamano_contador, 16, width of delivered-word counter

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  1 = drain FIFO; 0 = stop issuing reads
empty  input  1  FIFO empty flag
almost_empty  input  1  FIFO almost_empty flag (exactly one word stored)
fifo_error  input  1  FIFO error flag
fifo_data  input  tamano_datos  FIFO data_out; valid the cycle after read_enable
read_enable  output  1  pop request to FIFO
data_out  output  tamano_datos  word presented downstream
valid  output  1  data_out holds a word
ready  input  1  downstream accepts word when valid&&ready
words_read  output  tamano_contador  count of words accepted downstream
error  output  1  sticky error flag
busy  output  1  state != IDLE

Behaviour:
- One clock. Reset is synchronous and active-high, and wins over all other inputs. At reset: state=IDLE, read_enable=0, valid=0, data_out=0, words_read=0, error=0, busy=0, buffer cleared, in-flight flag cleared.
- FIFO read latency: fifo_data is captured on the edge after the cycle read_enable=1. An in-flight flag (inflight) marks that pending capture.
- Buffer: 2 entries, FIFO order. valid = occupancy>0. data_out = head entry. A handshake (valid&&ready) pops the head.
- Credit rule: read_enable=1 only when state=ACTIVE, empty=0, and occupancy + inflight - (valid&&ready) < 2. read_enable is combinational from registered state and inputs.
- Last-word guard: if almost_empty=1 and inflight=1, read_enable=0. This covers the cycle before empty updates after the final read.
- FSM:
  - IDLE -> ACTIVE when enable=1.
  - ACTIVE -> DRAIN when enable=0.
  - DRAIN: no new reads. -> IDLE when inflight=0 and occupancy=0. -> ACTIVE if enable=1 again.
- Simultaneous capture and pop with occupancy=2 is impossible by the credit rule. Capture and pop in the same cycle keep occupancy unchanged.
- words_read increments by 1 per handshake and wraps modulo 2^tamano_contador.
- error set by any of the following, held until reset:
  - fifo_error=1
  - read_enable=1 while empty=1 (defensive check)
  - handshake while valid=0 is ignored and does not set error
- data_out stays stable while valid=1 and ready=0.
- Reset mid-operation discards buffered and in-flight words; the FIFO's own reset is the caller's concern.

Decomposition:
- Shared include fifo_defs.vh: state encodings IDLE=2'b00, ACTIVE=2'b01, DRAIN=2'b10; default widths tamano_datos=10, tamano_contador=16.
- One sub-module, buffer_salida: the 2-entry FIFO-ordered output buffer with push/pop/occupancy.
- fifo_lector keeps the FSM, credit/guard logic, counter and error flag.

Test Plan:
- Reset for 2 cycles, then enable=1 with FIFO preloaded 0x001..0x004 and ready=1 -> data_out 0x001..0x004 on 4 consecutive valid cycles; words_read=4; empty seen; read_enable never high while empty=1; error=0.
- ready=0 for 6 cycles with 8 words queued -> at most 2 reads issued, valid=1, data_out held at 1st word. Release ready -> all 8 words arrive in order, no duplicates.
- FIFO holding exactly 1 word (almost_empty=1) -> exactly one read_enable pulse, one word delivered, busy drops after enable=0.
- enable 1 -> 0 while inflight=1 and occupancy=1 -> DRAIN delivers 2 remaining words, then IDLE; no further read_enable.
- Assert fifo_error for 1 cycle -> error=1 and stays 1 until reset; a reset pulse mid-stream -> valid=0, words_read=0 next cycle.
- tamano_contador=4, stream 17 words -> words_read wraps to 1.

Source files
------------

// File: rtl/fifo_lector_pkg.sv
// Shared definitions for the FIFO read-side controller.
//   state_e            : controller FSM encoding (IDLE/ACTIVE/DRAIN)
//   TAMANO_*_DEF       : default data / counter widths
//   BUF_DEPTH          : depth of the output buffer (credit limit)
package fifo_lector_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    DRAIN  = 2'b10
  } state_e;

  localparam int TAMANO_DATOS_DEF    = 10;
  localparam int TAMANO_CONTADOR_DEF = 16;
  localparam logic [2:0] BUF_DEPTH   = 3'd2;

endpackage

// File: rtl/fifo_lector_if.sv
// Downstream valid/ready word stream.
//   data_out : word presented downstream
//   valid    : data_out holds a word
//   ready    : sink accepts the word when valid && ready
// master = word source (the controller), slave = word sink.
interface fifo_lector_if #(parameter int W = 10) ();
  logic [W-1:0] data_out;
  logic         valid;
  logic         ready;

  modport master (output data_out, output valid, input ready);
  modport slave  (input data_out, input valid, output ready);
endinterface

// File: rtl/fifo_lector_buffer_salida.sv
// buffer_salida: 2-entry FIFO-ordered output buffer.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write din at the tail
//   pop        : drop the head entry (ignored when empty)
//   dout       : head entry (registered, stable until popped)
//   occ        : number of stored entries (0..2)
module buffer_salida #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   occ
);

  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   occ_q, occ_d;
  logic         pop_ok, push_ok;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    occ_d   = occ_q;
    pop_ok  = pop && (occ_q != 2'd0);
    // A push into a full buffer is only legal if the head leaves this cycle.
    push_ok = push && ((occ_q != 2'd2) || pop_ok);
    case ({push_ok, pop_ok})
      2'b11: begin
        // occupancy unchanged: the new word lands behind whatever remains
        if (occ_q == 2'd1) e0_d = din;
        else begin
          e0_d = e1_q;
          e1_d = din;
        end
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) e0_d = din;
        else               e1_d = din;
        occ_d = occ_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  assign dout = e0_q;
  assign occ  = occ_q;

endmodule

// File: rtl/fifo_lector.sv
// fifo_lector: read-side controller for the team FIFO.
// Pops words with read_enable, absorbs the FIFO's one-cycle read latency in a
// 2-entry output buffer and presents words on a valid/ready stream.
//   clk, reset        : clock, synchronous active-high reset
//   enable            : 1 = drain FIFO, 0 = stop issuing reads
//   empty/almost_empty/fifo_error/fifo_data : FIFO status and read data
//   read_enable       : pop request to the FIFO
//   dn (master)       : downstream data_out/valid/ready
//   words_read        : handshakes completed (wraps)
//   error             : sticky error flag
//   busy              : controller not IDLE
module fifo_lector
  import fifo_lector_pkg::*;
#(
  parameter int tamano_datos    = TAMANO_DATOS_DEF,
  parameter int tamano_contador = TAMANO_CONTADOR_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       empty,
  input  logic                       almost_empty,
  input  logic                       fifo_error,
  input  logic [tamano_datos-1:0]    fifo_data,
  output logic                       read_enable,
  fifo_lector_if.master              dn,
  output logic [tamano_contador-1:0] words_read,
  output logic                       error,
  output logic                       busy
);

  state_e                     state_q, state_d;
  logic                       inflight_q, inflight_d;
  logic                       error_q, error_d;
  logic [tamano_contador-1:0] cnt_q, cnt_d;
  logic [1:0]                 occ;
  logic                       hs;
  logic [2:0]                 pend;

  buffer_salida #(.W(tamano_datos)) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_q),   // read issued last cycle -> fifo_data valid now
    .pop   (hs),
    .din   (fifo_data),
    .dout  (dn.data_out),
    .occ   (occ)
  );

  assign dn.valid = (occ != 2'd0);
  assign hs       = dn.valid && dn.ready;

  always_comb begin
    // Credit: words held plus word in flight, minus the one leaving now.
    pend        = {1'b0, occ} + {2'b00, inflight_q};
    read_enable = (state_q == ACTIVE) && !empty
                  && (pend < BUF_DEPTH + {2'b00, hs})
                  // almost_empty may still describe the word already in flight
                  && !(almost_empty && inflight_q);

    inflight_d = read_enable;
    cnt_d      = cnt_q + {{(tamano_contador-1){1'b0}}, hs};
    error_d    = error_q | fifo_error | (read_enable & empty);

    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = ACTIVE;
      ACTIVE:  if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)                          state_d = ACTIVE;
        else if (!inflight_q && occ == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      error_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      error_q    <= error_d;
      cnt_q      <= cnt_d;
    end
  end

  assign words_read = cnt_q;
  assign error      = error_q;
  assign busy       = (state_q != IDLE);

endmodule
